instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder end of the core's instruction-fetch bus (req/gnt/rvalid, 32-bit, in-order).
- Word-organised instruction RAM with configurable fixed read latency, a cap on outstanding grants, injectable grant stalls and address-range error generation.
- Sits at the memory side of the fetch path: in simulation/FPGA top-levels as the instruction memory, and as the bus model driving prefetch-buffer verification.
- Includes a side-band load port for program image writes.

Parameters:
- Depth, 1024: RAM size in 32-bit words; power of two, >= 2.
- BaseAddr, 32'h0000_0000: byte address of word 0; aligned to 4*Depth.
- ReadLatency, 1: cycles from grant edge to rvalid; range 1..4.
- MaxOutstanding, 2: max granted-but-unanswered requests; range 1..4.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  request valid
- instr_addr_i  in  32  byte address; bits [1:0] ignored
- instr_gnt_o  out  1  request accepted this cycle
- instr_rvalid_o  out  1  response valid (single-cycle pulse per granted request)
- instr_rdata_o  out  32  read data
- instr_err_o  out  1  bus error for this response
- stall_i  in  1  verification hook: forces gnt low while high
- load_en_i  in  1  load-port write strobe
- load_addr_i  in  $clog2(Depth)  load word index
- load_data_i  in  32  load data
- busy_o  out  1  one or more requests outstanding

Behaviour:
- Reset: instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, busy_o=0; outstanding counter and response pipeline cleared. RAM contents are not reset.
- Reset mid-operation drops all in-flight responses; none are emitted after release.
- Grant (combinational): instr_gnt_o = instr_req_i & ~stall_i & (cnt_q < MaxOutstanding).
- A retiring rvalid in the same cycle does not free a slot for that cycle's grant.
- Grant is independent of address; no grant is issued without req.
- Requestor holds req/addr stable until granted. The responder samples addr only on the grant cycle.
- Counter cnt_q, width $clog2(MaxOutstanding+1):
  - +1 on grant, -1 on rvalid, unchanged on both.
  - Never exceeds MaxOutstanding; never underflows.
- busy_o = (cnt_q != 0).
- Response pipeline: ReadLatency-stage shift register carrying {valid, word index, err}.
  - A grant at cycle T gives instr_rvalid_o=1 at cycle T+ReadLatency for exactly one cycle.
  - Strictly in-order; back-to-back grants give back-to-back rvalids.
- Range check on the grant cycle: in range iff BaseAddr <= addr < BaseAddr + 4*Depth.
  - Word index = (addr - BaseAddr) >> 2.
- Error response: instr_err_o=1, instr_rdata_o=32'h0. Normal response: instr_err_o=0, rdata = RAM[index].
- RAM read is synchronous, issued in the last pipeline stage; rdata is registered. For ReadLatency=1 the read happens on the grant cycle.
- instr_rdata_o / instr_err_o hold their last values when rvalid=0. Consumers qualify on rvalid.
- Load port: RAM[load_addr_i] <= load_data_i on the clock edge when load_en_i=1.
  - Same-cycle read and load to the same word returns the OLD data (read-before-write).
  - Load is legal at any time, including while requests are outstanding.
- No cancel or abort: the requestor discards unwanted responses itself. Every grant produces exactly one rvalid unless reset intervenes.

Test Plan:
- Reset, then load RAM[0..3] = 0x11,0x22,0x33,0x44. Hold req, addr 0x0,0x4,0x8,0xC (ReadLatency=1, MaxOutstanding=2) -> gnt every cycle; rvalid on the next cycle with rdata 0x11,0x22,0x33,0x44 and err=0; busy_o=1 throughout, 0 after the last rvalid.
- ReadLatency=3, MaxOutstanding=2, req held continuously -> gnt at cycles 0 and 1; gnt low at cycles 2 and 3; rvalid at 3 and 4; next gnt at 4; cnt_q never exceeds 2.
- Addr 0x0000_1000 with Depth=1024, BaseAddr=0 (out of range) -> gnt, then rvalid=1, err=1, rdata=0. Following addr 0x0000_0FFC -> err=0, rdata=RAM[1023].
- stall_i high for 3 cycles with req held at addr 0x8 -> gnt=0 for those cycles and addr sampled only on the first cycle after stall drops; single rvalid returns RAM[2].
- Load RAM[5]=0xDEAD_BEEF on the same cycle as the read of 0x14 is performed -> response returns the old value; next read of 0x14 returns 0xDEADBEEF.
- Assert rst_ni low with 2 responses in flight (ReadLatency=3) -> no rvalid after reset release; busy_o=0; next request is served normally.

Source files
------------

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: memory-side responder for the in-order req/gnt/rvalid instruction-fetch bus.
// Ports: clk_i/rst_ni clock and asynchronous active-low reset;
//        instr_req_i/instr_addr_i/instr_gnt_o request channel (grant is combinational);
//        instr_rvalid_o/instr_rdata_o/instr_err_o response channel (data and err are registered);
//        stall_i holds grant low; load_en_i/load_addr_i/load_data_i side-band RAM writes;
//        busy_o is high while any granted request is still unanswered.
module instr_mem_responder #(
    parameter int unsigned Depth          = 1024,
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned ReadLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     instr_req_i,
    input  logic [31:0]              instr_addr_i,
    output logic                     instr_gnt_o,
    output logic                     instr_rvalid_o,
    output logic [31:0]              instr_rdata_o,
    output logic                     instr_err_o,
    input  logic                     stall_i,
    input  logic                     load_en_i,
    input  logic [$clog2(Depth)-1:0] load_addr_i,
    input  logic [31:0]              load_data_i,
    output logic                     busy_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    logic [31:0]            ram [Depth];
    logic [CW-1:0]          cnt_q;
    logic [ReadLatency-1:0] v_q;
    logic [31:0]            rdata_q;
    logic                   err_q;
    logic                   in_rng;
    logic                   rd_v;
    logic                   rd_e;
    logic [AW-1:0]          rd_idx;
    logic                   unused_addr;
    assign unused_addr = ^instr_addr_i[1:0];
    // BaseAddr is aligned to the RAM span, so the range check reduces to matching the upper address bits.
    assign in_rng         = instr_addr_i[31:AW+2] == BaseAddr[31:AW+2];
    assign instr_gnt_o    = instr_req_i && !stall_i && cnt_q < CW'(MaxOutstanding);
    assign instr_rvalid_o = v_q[ReadLatency-1];
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;
    assign busy_o         = cnt_q != '0;
    // The RAM read is performed one stage before rvalid so that rdata lands in its register together with rvalid.
    if (ReadLatency == 1) begin : g_rd_now
        assign rd_v   = instr_gnt_o;
        assign rd_e   = !in_rng;
        assign rd_idx = instr_addr_i[AW+1:2];
    end else begin : g_rd_pipe
        localparam int unsigned PL = ReadLatency - 1;
        logic [PL-1:0] e_q;
        logic [AW-1:0] idx_q [PL];
        always_ff @(posedge clk_i) begin
            e_q      <= PL'({e_q, !in_rng});
            idx_q[0] <= instr_addr_i[AW+1:2];
            for (int k = 1; k < PL; k++) idx_q[k] <= idx_q[k-1];
        end
        assign rd_v   = v_q[PL-1];
        assign rd_e   = e_q[PL-1];
        assign rd_idx = idx_q[PL-1];
    end
    always_ff @(posedge clk_i) begin
        if (load_en_i) ram[load_addr_i] <= load_data_i;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            v_q   <= '0;
        end else begin
            v_q   <= ReadLatency'({v_q, instr_gnt_o});
            cnt_q <= cnt_q + CW'(instr_gnt_o) - CW'(instr_rvalid_o);
        end
    end
    // Reading ram here while the load port writes it on the same edge yields the old word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (rd_v) begin
            rdata_q <= rd_e ? 32'h0 : ram[rd_idx];
            err_q   <= rd_e;
        end
    end
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench driving one ReadLatency=1 and one ReadLatency=3 responder.
module tb_instr_mem_responder;
    localparam int          DEPTH = 1024;
    localparam longint      BASE  = 0;
    localparam int          MAXO  = 2;
    typedef struct {
        int          t;
        int          due;
        logic [9:0]  idx;
        logic        err;
        logic [31:0] data;
    } ent_t;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req [2];
    logic        stall [2];
    logic        load_en [2];
    logic [31:0] addr [2];
    logic [31:0] load_data [2];
    logic [9:0]  load_addr [2];
    logic        gnt [2];
    logic        rvalid [2];
    logic        err [2];
    logic        busy [2];
    logic [31:0] rdata [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    always #5 clk = ~clk;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction
    for (genvar d = 0; d < 2; d++) begin : g
        localparam int L = (d == 0) ? 1 : 3;
        ent_t        pend[$];
        ent_t        res[$];
        ent_t        e;
        logic [31:0] mem [DEPTH];
        int          cyc = 0;
        int          outst;
        logic        g_exp;
        logic        v_exp;
        longint      off;
        instr_mem_responder #(
            .Depth(DEPTH), .BaseAddr(32'(BASE)), .ReadLatency(L), .MaxOutstanding(MAXO)
        ) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .instr_req_i(req[d]), .instr_addr_i(addr[d]), .instr_gnt_o(gnt[d]),
            .instr_rvalid_o(rvalid[d]), .instr_rdata_o(rdata[d]), .instr_err_o(err[d]),
            .stall_i(stall[d]), .load_en_i(load_en[d]), .load_addr_i(load_addr[d]),
            .load_data_i(load_data[d]), .busy_o(busy[d])
        );
        // Model: a grant at cycle T reads memory at cycle T+L-1 (before that cycle's load lands)
        // and must be answered exactly at cycle T+L; outstanding = granted and not yet past its answer cycle.
        always @(negedge clk) begin
            cyc++;
            if (!rst_n) begin
                pend.delete();
                res.delete();
                chk($sformatf("d%0d reset rvalid @%0d", d, cyc), 32'(rvalid[d]), 0);
                chk($sformatf("d%0d reset busy @%0d", d, cyc), 32'(busy[d]), 0);
                chk($sformatf("d%0d reset rdata @%0d", d, cyc), rdata[d], 0);
                chk($sformatf("d%0d reset err @%0d", d, cyc), 32'(err[d]), 0);
            end else begin
                outst = pend.size() + res.size();
                g_exp = req[d] && !stall[d] && outst < MAXO;
                chk($sformatf("d%0d gnt @%0d", d, cyc), 32'(gnt[d]), 32'(g_exp));
                chk($sformatf("d%0d busy @%0d", d, cyc), 32'(busy[d]), 32'(outst != 0));
                v_exp = res.size() != 0 && res[0].due == cyc;
                chk($sformatf("d%0d rvalid @%0d", d, cyc), 32'(rvalid[d]), 32'(v_exp));
                if (v_exp) begin
                    e = res.pop_front();
                    if (rvalid[d]) begin
                        chk($sformatf("d%0d rdata @%0d", d, cyc), rdata[d], e.data);
                        chk($sformatf("d%0d err @%0d", d, cyc), 32'(err[d]), 32'(e.err));
                    end
                end
                if (g_exp) begin
                    off   = longint'({32'h0, addr[d]}) - BASE;
                    e.t   = cyc;
                    e.err = off < 0 || off >= 4 * DEPTH;
                    e.idx = 10'(off >>> 2);
                    pend.push_back(e);
                end
                while (pend.size() != 0 && pend[0].t + L - 1 == cyc) begin
                    e      = pend.pop_front();
                    e.data = e.err ? 32'h0 : mem[e.idx];
                    e.due  = cyc + 1;
                    res.push_back(e);
                end
            end
            if (load_en[d]) mem[load_addr[d]] = load_data[d];
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) tick();
    endtask
    task automatic load(input int d, input int a, input logic [31:0] v);
        load_en[d]   = 1'b1;
        load_addr[d] = 10'(a);
        load_data[d] = v;
        tick();
        load_en[d] = 1'b0;
    endtask
    task automatic fetch(input int d, input logic [31:0] a);
        int n;
        req[d]  = 1'b1;
        addr[d] = a;
        for (n = 0; n < 64; n++) begin
            @(negedge clk);
            if (gnt[d]) break;
            tick();
        end
        chk($sformatf("d%0d grant within bound", d), 32'(n < 64), 1);
        tick();
        req[d] = 1'b0;
    endtask
    task automatic rand_run(input int d, input int n);
        logic gd;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            gd = gnt[d];
            tick();
            if (!req[d] || gd) begin
                req[d]  = 1'($urandom_range(0, 1));
                addr[d] = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            end
            stall[d]     = $urandom_range(0, 3) == 0;
            load_en[d]   = $urandom_range(0, 3) == 0;
            load_addr[d] = 10'($urandom_range(0, DEPTH - 1));
            load_data[d] = $urandom;
        end
        tick();
        req[d]     = 1'b0;
        stall[d]   = 1'b0;
        load_en[d] = 1'b0;
    endtask
    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; stall[d] = 1'b0; load_en[d] = 1'b0;
            addr[d] = '0; load_addr[d] = '0; load_data[d] = '0;
        end
        idle(3);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            for (int d = 0; d < 2; d++) begin
                load_en[d] = 1'b1; load_addr[d] = 10'(i); load_data[d] = $urandom;
            end
            tick();
        end
        for (int d = 0; d < 2; d++) load_en[d] = 1'b0;
        load(0, 0, 32'h11); load(0, 1, 32'h22); load(0, 2, 32'h33); load(0, 3, 32'h44);
        fetch(0, 32'h0); fetch(0, 32'h4); fetch(0, 32'h8); fetch(0, 32'hC);
        idle(4);
        fetch(1, 32'h10); fetch(1, 32'h14); fetch(1, 32'h18);
        idle(6);
        fetch(0, 32'h0000_1000); fetch(0, 32'h0000_0FFC); fetch(0, 32'hFFFF_FFFC);
        idle(4);
        stall[0] = 1'b1; req[0] = 1'b1; addr[0] = 32'h8;
        idle(3);
        stall[0] = 1'b0;
        fetch(0, 32'h8);
        idle(4);
        load_en[0] = 1'b1; load_addr[0] = 10'd5; load_data[0] = 32'hDEAD_BEEF;
        fetch(0, 32'h14);
        load_en[0] = 1'b0;
        fetch(0, 32'h14);
        idle(4);
        fetch(1, 32'h14);
        tick();
        load(1, 5, 32'hCAFE_F00D);
        idle(4);
        fetch(1, 32'h14);
        idle(6);
        fetch(1, 32'h0); fetch(1, 32'h4);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        fetch(1, 32'h8);
        idle(6);
        fork
            rand_run(0, 400);
            rand_run(1, 400);
        join
        idle(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
